core_dispatcher: RTL and testbench

//  Supervisor at the opposite end of each core's status/end_process handshake.
//  - Launches up to NUM_CORES matrix-multiply cores by driving their 2-bit status inputs.
//  - Collects each core's end_process.
//  - Acknowledges finished cores and reports one job-done event to the host.
//  - A watchdog aborts jobs that hang.

---
 rtl/core_dispatcher.sv | 157 +++++++++++++++
 tb/tb_core_dispatcher.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_dispatcher.sv
// Supervisor for up to NUM_CORES matrix-multiply cores: launches them over the 2-bit
// status command lines, gathers end_process, acknowledges, and aborts hung jobs.
module core_dispatcher #(
    parameter int          NUM_CORES = 4,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF,
    parameter int          CNT_W     = 32
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             num_active,
    input  logic [NUM_CORES-1:0]   end_process,
    output logic [2*NUM_CORES-1:0] status,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [CNT_W-1:0]       cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_ACK,
        S_ABORT
    } state_t;

    localparam logic [1:0] CMD_HOLD  = 2'b00;
    localparam logic [1:0] CMD_GO    = 2'b01;
    localparam logic [1:0] CMD_ABORT = 2'b10;
    localparam logic [1:0] CMD_ACK   = 2'b11;
    localparam logic [3:0] MAX_N     = 4'(NUM_CORES);

    state_t                 state_q, state_d;
    logic [3:0]             n_q, n_d;
    logic [NUM_CORES-1:0]   finished_q, finished_d;
    logic [CNT_W-1:0]       cycle_count_q, cycle_count_d;
    logic [15:0]            wd_q, wd_d;
    logic                   timeout_q, timeout_d;
    logic                   done_q, done_d;
    logic                   busy_q, busy_d;
    logic [2*NUM_CORES-1:0] status_q, status_d;

    logic [3:0]             n_req;
    logic [NUM_CORES-1:0]   active_mask;
    logic [NUM_CORES-1:0]   active_end;

    always_comb begin
        n_req       = (num_active > MAX_N) ? MAX_N : num_active;
        active_mask = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            active_mask[i] = (4'(i) < n_q);
        end
        active_end = end_process & active_mask;
    end

    // The watchdog counter is kept apart from cycle_count so a narrow CNT_W that
    // saturates early can never stop the abort from firing.
    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        finished_d    = finished_q;
        cycle_count_d = cycle_count_q;
        wd_d          = wd_q;
        timeout_d     = timeout_q;
        done_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (n_req != 4'd0)) begin
                    state_d       = S_LAUNCH;
                    n_d           = n_req;
                    finished_d    = '0;
                    cycle_count_d = '0;
                    wd_d          = '0;
                    timeout_d     = 1'b0;
                end
            end
            S_LAUNCH: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                finished_d = finished_q | active_end;
                wd_d       = wd_q + 16'd1;
                if (cycle_count_q != '1) begin
                    cycle_count_d = cycle_count_q + CNT_W'(1);
                end
                if (&(finished_d | ~active_mask)) begin
                    state_d = S_ACK;
                end else if (wd_d >= TIMEOUT) begin
                    state_d = S_ABORT;
                end
            end
            S_ACK: begin
                if (active_end == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ABORT: begin
                state_d   = S_IDLE;
                timeout_d = 1'b1;
                done_d    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Commands are registered for the state being entered, so they line up with it.
    always_comb begin
        status_d = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            status_d[2*i +: 2] = CMD_HOLD;
            if (active_mask[i]) begin
                case (state_d)
                    S_RUN:   status_d[2*i +: 2] = finished_d[i] ? CMD_HOLD : CMD_GO;
                    S_ACK:   status_d[2*i +: 2] = CMD_ACK;
                    S_ABORT: status_d[2*i +: 2] = CMD_ABORT;
                    default: status_d[2*i +: 2] = CMD_HOLD;
                endcase
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            finished_q    <= '0;
            cycle_count_q <= '0;
            wd_q          <= '0;
            timeout_q     <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            status_q      <= '0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            finished_q    <= finished_d;
            cycle_count_q <= cycle_count_d;
            wd_q          <= wd_d;
            timeout_q     <= timeout_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            status_q      <= status_d;
        end
    end

    assign status      = status_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_core_dispatcher.sv
// Bench for core_dispatcher: directed job scenarios followed by random traffic, all
// checked against a job-level reference model of the dispatcher.
module tb_core_dispatcher;

    localparam int          NC       = 4;
    localparam logic [15:0] TO       = 16'd20;
    localparam int          CW       = 32;
    localparam int          CW_SMALL = 4;

    logic              clock = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        num_active;
    logic [NC-1:0]     end_process;
    logic [2*NC-1:0]   status, status_s;
    logic              busy, done, timeout;
    logic              busy_s, done_s, timeout_s;
    logic [CW-1:0]     cycle_count;
    logic [CW_SMALL-1:0] cycle_count_s;

    int vectors     = 0;
    int miscompares = 0;

    core_dispatcher #(.NUM_CORES(NC), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock(clock), .rst(rst), .start(start), .num_active(num_active),
        .end_process(end_process), .status(status), .busy(busy), .done(done),
        .timeout(timeout), .cycle_count(cycle_count)
    );

    // Narrow-counter copy so cycle_count saturation is reachable within a short job.
    core_dispatcher #(.NUM_CORES(NC), .TIMEOUT(TO), .CNT_W(CW_SMALL)) dut_small (
        .clock(clock), .rst(rst), .start(start), .num_active(num_active),
        .end_process(end_process), .status(status_s), .busy(busy_s), .done(done_s),
        .timeout(timeout_s), .cycle_count(cycle_count_s)
    );

    always #5 clock = ~clock;

    typedef enum {M_IDLE, M_LAUNCH, M_RUN, M_ACK, M_ABORT} phase_t;

    phase_t m_phase;
    int     m_n;
    bit     m_fin [NC];
    longint m_runs;
    bit     m_timeout;
    bit     m_done;

    task automatic model_reset();
        m_phase   = M_IDLE;
        m_n       = 0;
        m_runs    = 0;
        m_timeout = 0;
        m_done    = 0;
        for (int i = 0; i < NC; i++) m_fin[i] = 0;
    endtask

    // One rising edge of the job-level model, using the inputs held during the cycle.
    task automatic model_edge();
        int  want;
        bit  all_fin;
        bit  any_end;
        bit  next_done;
        next_done = 0;
        case (m_phase)
            M_IDLE: begin
                want = (int'(num_active) > NC) ? NC : int'(num_active);
                if (start && want > 0) begin
                    m_phase   = M_LAUNCH;
                    m_n       = want;
                    m_runs    = 0;
                    m_timeout = 0;
                    for (int i = 0; i < NC; i++) m_fin[i] = 0;
                end
            end
            M_LAUNCH: m_phase = M_RUN;
            M_RUN: begin
                m_runs++;
                all_fin = 1;
                for (int i = 0; i < m_n; i++) begin
                    if (end_process[i]) m_fin[i] = 1;
                    if (!m_fin[i]) all_fin = 0;
                end
                if (all_fin) m_phase = M_ACK;
                else if (m_runs >= longint'(TO)) m_phase = M_ABORT;
            end
            M_ACK: begin
                any_end = 0;
                for (int i = 0; i < m_n; i++) if (end_process[i]) any_end = 1;
                if (!any_end) begin
                    m_phase   = M_IDLE;
                    next_done = 1;
                end
            end
            M_ABORT: begin
                m_phase   = M_IDLE;
                m_timeout = 1;
                next_done = 1;
            end
            default: m_phase = M_IDLE;
        endcase
        m_done = next_done;
    endtask

    function automatic logic [2*NC-1:0] expected_status();
        logic [2*NC-1:0] s;
        s = '0;
        for (int i = 0; i < m_n; i++) begin
            case (m_phase)
                M_RUN:   s[2*i +: 2] = m_fin[i] ? 2'b00 : 2'b01;
                M_ACK:   s[2*i +: 2] = 2'b11;
                M_ABORT: s[2*i +: 2] = 2'b10;
                default: s[2*i +: 2] = 2'b00;
            endcase
        end
        return s;
    endfunction

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [CW-1:0]       exp_cnt;
        logic [CW_SMALL-1:0] exp_cnt_s;
        exp_cnt   = CW'(m_runs);
        exp_cnt_s = (m_runs >= 15) ? 4'hF : CW_SMALL'(m_runs);
        compare({tag, "/status"},  status,  expected_status());
        compare({tag, "/busy"},    busy,    m_phase != M_IDLE);
        compare({tag, "/done"},    done,    m_done);
        compare({tag, "/timeout"}, timeout, m_timeout);
        compare({tag, "/count"},   cycle_count, exp_cnt);
        compare({tag, "/status_s"},  status_s, expected_status());
        compare({tag, "/timeout_s"}, timeout_s, m_timeout);
        compare({tag, "/count_s"},   cycle_count_s, exp_cnt_s);
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] na, input logic [NC-1:0] ep);
        start       = s;
        num_active  = na;
        end_process = ep;
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 4'd0, '0);
        model_reset();
        #2;
        checkOutput("reset_t0");
        @(posedge clock);
        #1;
        checkOutput("reset_held");
        #3 rst = 1'b0;

        // Two cores, core1 ends at RUN+5, core0 at RUN+9.
        applyStimulus(1'b1, 4'd2, 4'b0000); step("t1_accept");
        compare("t1_launch_hold", status, 8'h00);
        applyStimulus(1'b0, 4'd2, 4'b0000); step("t1_launch");
        compare("t1_go", status, 8'h05);
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b0, 4'd2, {2'b00, (j >= 5), (j >= 9)});
            step("t1_run");
            if (j == 5) compare("t1_core1_hold", status, 8'h01);
        end
        compare("t1_ack", status, 8'h0F);
        applyStimulus(1'b0, 4'd2, 4'b0011); step("t1_ack_hold");
        applyStimulus(1'b0, 4'd2, 4'b0000); step("t1_release");
        compare("t1_done", done, 1'b1);
        compare("t1_count", cycle_count, 32'd10);
        step("t1_after");
        compare("t1_done_pulse", done, 1'b0);

        // Zero active cores is ignored; oversize count clamps to all cores.
        applyStimulus(1'b1, 4'd0, 4'b0000); step("t2_zero");
        compare("t2_zero_busy", busy, 1'b0);
        applyStimulus(1'b1, 4'd9, 4'b0000); step("t2_accept");
        applyStimulus(1'b0, 4'd9, 4'b0000); step("t2_launch");
        compare("t2_clamp", status, 8'h55);
        applyStimulus(1'b0, 4'd9, 4'b1111); step("t2_end");
        compare("t2_ack", status, 8'hFF);
        applyStimulus(1'b0, 4'd9, 4'b0000); step("t2_release");
        step("t2_idle");

        // Watchdog abort with one core that never finishes.
        applyStimulus(1'b1, 4'd1, 4'b0000); step("t3_accept");
        applyStimulus(1'b0, 4'd1, 4'b0000); step("t3_launch");
        for (int j = 0; j < 20; j++) step("t3_run");
        compare("t3_abort", status, 8'h02);
        step("t3_abort_exit");
        compare("t3_timeout", timeout, 1'b1);
        compare("t3_done", done, 1'b1);
        compare("t3_sat", cycle_count_s, 4'hF);
        step("t3_idle");

        // Completion in the same cycle the watchdog expires wins; start clears timeout.
        applyStimulus(1'b1, 4'd1, 4'b0000); step("t4_accept");
        compare("t4_timeout_clr", timeout, 1'b0);
        applyStimulus(1'b0, 4'd1, 4'b0000); step("t4_launch");
        for (int j = 0; j < 20; j++) begin
            applyStimulus(1'b0, 4'd1, {3'b000, (j == 19)});
            step("t4_run");
        end
        compare("t4_ack", status, 8'h03);
        compare("t4_no_timeout", timeout, 1'b0);
        applyStimulus(1'b0, 4'd1, 4'b0000); step("t4_release");
        step("t4_idle");

        // Asynchronous reset in the middle of RUN.
        applyStimulus(1'b1, 4'd3, 4'b0000); step("t5_accept");
        applyStimulus(1'b0, 4'd3, 4'b0000); step("t5_launch");
        for (int j = 0; j < 3; j++) step("t5_run");
        compare("t5_running", status, 8'h15);
        #3 rst = 1'b1;
        #1;
        model_reset();
        checkOutput("t5_async");
        compare("t5_status_clr", status, 8'h00);
        @(posedge clock);
        #1;
        checkOutput("t5_held");
        #3 rst = 1'b0;
        applyStimulus(1'b1, 4'd2, 4'b0000); step("t5_accept2");
        applyStimulus(1'b0, 4'd2, 4'b0000); step("t5_launch2");
        compare("t5_go2", status, 8'h05);
        applyStimulus(1'b0, 4'd2, 4'b0011); step("t5_end2");
        applyStimulus(1'b0, 4'd2, 4'b0000); step("t5_release2");
        step("t5_idle2");

        // Start held through the job with stale end_process present before launch.
        applyStimulus(1'b1, 4'd4, 4'b1111); step("t6_accept");
        applyStimulus(1'b1, 4'd4, 4'b1111); step("t6_launch");
        compare("t6_go", status, 8'h55);
        applyStimulus(1'b1, 4'd4, 4'b0000); step("t6_run");
        compare("t6_not_stale", status, 8'h55);
        applyStimulus(1'b1, 4'd4, 4'b1111); step("t6_end");
        applyStimulus(1'b0, 4'd4, 4'b0000); step("t6_release");
        compare("t6_done", done, 1'b1);
        step("t6_idle");
        compare("t6_single_job", busy, 1'b0);

        // Random traffic, occasionally interrupted by an asynchronous reset.
        for (int c = 0; c < 800; c++) begin
            logic [NC-1:0] ep;
            for (int b = 0; b < NC; b++) ep[b] = ($urandom_range(0, 5) == 0);
            applyStimulus($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), ep);
            step("rand");
            if ($urandom_range(0, 79) == 0) begin
                #3 rst = 1'b1;
                #1;
                model_reset();
                checkOutput("rand_reset");
                #2 rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
